// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer
// ----------------------------------------------------------------------------
// Owns the fetch PC and picks the next one each cycle: sequential PC+4 or a
// redirect (branch/j/jal/jr) coming from the ID stage. The PC freezes while
// the hazard unit stalls or instruction memory is waiting.
//
// A redirect has delay-slot semantics. The word at the current pc is the
// delay slot. If that word cannot be fetched yet, the target is parked in
// pend_target_reg, and the PC moves once the delay slot has been delivered.
//
// Optional feature macro: PC_ALIGN_CHK_EN
//   When defined, a redirect whose target[1:0] != 0 sends the PC to EXC_VEC
//   instead and raises pc_adel for that cycle. When undefined, no check is
//   made and pc_adel is tied low.
//
// Ports
//   clk           in   1   clock, rising edge
//   reset         in   1   asynchronous, active-low reset
//   id_stall      in   1   hazard stall: PC and IF/ID frozen
//   imem_wait     in   1   instruction memory cannot return the word at pc
//   redir_valid   in   1   ID instruction is a taken branch/jump
//   redir_target  in   32  redirect target
//   pc            out  32  fetch address
//   pc4           out  32  pc + 4 (wraps)
//   if_valid      out  1   word at pc is valid this cycle
//   ifid_en       out  1   IF/ID write enable
//   redir_pend    out  1   redirect waiting for its delay slot
//   fetch_cnt     out  32  instructions delivered to IF/ID (wraps)
//   pc_adel       out  1   misaligned redirect taken (feature macro only)
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_stall,
    input  logic        imem_wait,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        if_valid,
    output logic        ifid_en,
    output logic        redir_pend,
    output logic [31:0] fetch_cnt,
    output logic        pc_adel
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pend_target_reg, pend_target_next;
    logic [31:0] fetch_cnt_reg, fetch_cnt_next;
    logic        adel_reg, adel_next;

    // Redirect actually being applied to pc this cycle, and its target.
    logic        apply;
    logic [31:0] apply_target;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_PC;
            pend_target_reg <= 32'h0;
            fetch_cnt_reg   <= 32'h0;
            adel_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pend_target_reg <= pend_target_next;
            fetch_cnt_reg   <= fetch_cnt_next;
            adel_reg        <= adel_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-pc
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pend_target_next = pend_target_reg;
        apply            = 1'b0;
        apply_target     = redir_target;
        pc_next          = pc_reg;
        adel_next        = 1'b0;

        case (state_reg)
            BOOT: begin
                // First fetch happens at RESET_PC, so pc is left alone.
                state_next = RUN;
            end
            RUN: begin
                if (!id_stall) begin
                    if (redir_valid && !imem_wait) begin
                        apply        = 1'b1;
                        apply_target = redir_target;
                    end else if (redir_valid) begin
                        pend_target_next = redir_target;
                        state_next       = PEND;
                    end else if (!imem_wait) begin
                        pc_next = pc_reg + 32'd4;
                    end
                end
            end
            PEND: begin
                // A second redir_valid here is a protocol error; the first
                // target is kept.
                if (!id_stall && !imem_wait) begin
                    apply        = 1'b1;
                    apply_target = pend_target_reg;
                    state_next   = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase

        if (apply) begin
`ifdef PC_ALIGN_CHK_EN
            if (apply_target[1:0] != 2'b00) begin
                pc_next   = EXC_VEC;
                adel_next = 1'b1;
            end else begin
                pc_next = apply_target;
            end
`else
            pc_next = apply_target;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign if_valid       = (state_reg != BOOT) && !imem_wait;
    assign ifid_en        = !id_stall;
    assign redir_pend     = (state_reg == PEND);
    assign pc             = pc_reg;
    assign pc4            = pc_reg + 32'd4;
    assign fetch_cnt      = fetch_cnt_reg;
    assign fetch_cnt_next = fetch_cnt_reg + {31'h0, (if_valid && !id_stall)};

`ifdef PC_ALIGN_CHK_EN
    assign pc_adel = adel_reg;
`else
    // Without the alignment check the flag register never sets.
    logic unused_exc_vec;
    assign unused_exc_vec = ^{EXC_VEC, adel_reg};
    assign pc_adel        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_stall, imem_wait, redir_valid;
    logic [31:0] redir_target;
    logic [31:0] pc, pc4, fetch_cnt;
    logic        if_valid, ifid_en, redir_pend, pc_adel;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .id_stall     (id_stall),
        .imem_wait    (imem_wait),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .pc           (pc),
        .pc4          (pc4),
        .if_valid     (if_valid),
        .ifid_en      (ifid_en),
        .redir_pend   (redir_pend),
        .fetch_cnt    (fetch_cnt),
        .pc_adel      (pc_adel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reset held for two edges, released just after a rising edge so the
    // next edge is the BOOT->RUN edge.
    task automatic do_reset();
        reset = 1'b0;
        id_stall = 0; imem_wait = 0; redir_valid = 0; redir_target = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Drive inputs at the falling edge; leaves time just before the next
    // rising edge for combinational checks.
    task automatic drive(input logic s, input logic w, input logic r, input logic [31:0] t);
        @(negedge clk);
        id_stall = s; imem_wait = w; redir_valid = r; redir_target = t;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        s, w, r;
        logic [31:0] tgt;
        logic        exp_ifv;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic [31:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(logic s, logic w, logic r, logic [31:0] tgt,
                                logic ifv, logic [31:0] epc, logic epend, logic [31:0] ecnt);
        vec_t v;
        v.s = s; v.w = w; v.r = r; v.tgt = tgt;
        v.exp_ifv = ifv; v.exp_pc = epc; v.exp_pend = epend; v.exp_cnt = ecnt;
        return v;
    endfunction

    vec_t tbl[$];

    // Reference model: behaviour as a list of rules, pending redirect kept
    // as a queue of at most one target.
    bit          m_boot;
    logic [31:0] m_pc, m_cnt;
    logic [31:0] m_pendq[$];
    bit          m_adel;

    task automatic m_reset();
        m_boot = 1; m_pc = 32'h3000; m_cnt = 0; m_pendq = {}; m_adel = 0;
    endtask

    task automatic m_goto(input logic [31:0] t);
`ifdef PC_ALIGN_CHK_EN
        if (t % 4 != 0) begin m_pc = 32'h4180; m_adel = 1; end
        else m_pc = t;
`else
        m_pc = t;
`endif
    endtask

    task automatic m_edge(input logic s, input logic w, input logic r, input logic [31:0] t);
        bit delivered;
        delivered = !m_boot && !w;
        if (delivered && !s) m_cnt = m_cnt + 1;
        m_adel = 0;
        if (m_boot) m_boot = 0;
        else if (s) ;
        else if (m_pendq.size() != 0) begin
            if (!w) m_goto(m_pendq.pop_front());
        end else if (r) begin
            if (!w) m_goto(t);
            else m_pendq.push_back(t);
        end else if (!w) m_pc = m_pc + 4;
    endtask

    initial begin
        // ---------------- reset values ----------------
        reset = 1'b0;
        id_stall = 0; imem_wait = 0; redir_valid = 0; redir_target = 0;
        #12;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_ifv", {31'h0, if_valid}, 0);
        chk("rst_pend", {31'h0, redir_pend}, 0);
        chk("rst_cnt", fetch_cnt, 0);
        chk("rst_adel", {31'h0, pc_adel}, 0);

        // ---------------- directed table ----------------
        tbl.push_back(mk(0,0,0,0,          0,32'h3000,0,0)); // BOOT
        tbl.push_back(mk(0,0,0,0,          1,32'h3004,0,1));
        tbl.push_back(mk(0,0,0,0,          1,32'h3008,0,2));
        tbl.push_back(mk(0,0,0,0,          1,32'h300c,0,3));
        tbl.push_back(mk(0,0,0,0,          1,32'h3010,0,4));
        tbl.push_back(mk(0,1,1,32'h3200,   0,32'h3010,1,4)); // park redirect
        tbl.push_back(mk(0,1,1,32'h3300,   0,32'h3010,1,4)); // second ignored
        tbl.push_back(mk(0,0,0,0,          1,32'h3200,0,5)); // delay slot out
        tbl.push_back(mk(0,0,0,0,          1,32'h3204,0,6));
        tbl.push_back(mk(0,0,1,32'h3100,   1,32'h3100,0,7)); // immediate redirect
        tbl.push_back(mk(1,0,1,32'h3500,   1,32'h3100,0,7)); // stalls
        tbl.push_back(mk(1,0,0,0,          1,32'h3100,0,7));
        tbl.push_back(mk(1,0,1,32'h3500,   1,32'h3100,0,7));
        tbl.push_back(mk(0,1,1,32'h3600,   0,32'h3100,1,7));
        tbl.push_back(mk(1,0,0,0,          1,32'h3100,1,7)); // stall in PEND
        tbl.push_back(mk(0,0,0,0,          1,32'h3600,0,8));
        tbl.push_back(mk(0,1,1,32'h3700,   0,32'h3600,1,8)); // into PEND again

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].tgt);
            chk($sformatf("v%0d_ifv", i), {31'h0, if_valid}, {31'h0, tbl[i].exp_ifv});
            chk($sformatf("v%0d_ifid_en", i), {31'h0, ifid_en}, {31'h0, ~tbl[i].s});
            edge_wait();
            chk($sformatf("v%0d_pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("v%0d_pend", i), {31'h0, redir_pend}, {31'h0, tbl[i].exp_pend});
            chk($sformatf("v%0d_cnt", i), fetch_cnt, tbl[i].exp_cnt);
            $display("vec %0d: pc=%h pend=%0b cnt=%0d", i, pc, redir_pend, fetch_cnt);
        end

        // ---------------- async reset while pending ----------------
        @(negedge clk);
        id_stall = 0; imem_wait = 0; redir_valid = 0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_pc", pc, 32'h3000);
        chk("midrst_pend", {31'h0, redir_pend}, 0);
        chk("midrst_cnt", fetch_cnt, 0);
        @(posedge clk); #1 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0);
            edge_wait();
            chk($sformatf("postrst_pc%0d", k), pc, 32'h3000 + 4 * k);
            $display("post-reset %0d: pc=%h", k, pc);
        end

        // ---------------- misaligned redirect ----------------
        drive(0, 0, 1, 32'h3102);
        edge_wait();
`ifdef PC_ALIGN_CHK_EN
        chk("adel_pc", pc, 32'h4180);
        chk("adel_flag", {31'h0, pc_adel}, 1);
`else
        chk("adel_pc", pc, 32'h3102);
        chk("adel_flag", {31'h0, pc_adel}, 0);
`endif
        drive(0, 0, 0, 0);
        edge_wait();
        chk("adel_clear", {31'h0, pc_adel}, 0);
        $display("misaligned redirect: pc=%h adel=%0b", pc, pc_adel);

        // ---------------- randomized vs. model ----------------
        do_reset();
        m_reset();
        for (int n = 0; n < 500; n++) begin
            logic s, w, r;
            logic [31:0] t;
            s = ($urandom_range(0, 5) == 0);
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 4) == 0);
            t = $urandom & 32'hffff_fffc;
            if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
            drive(s, w, r, t);
            chk("rnd_ifv", {31'h0, if_valid}, {31'h0, (!m_boot && !w)});
            chk("rnd_ifid_en", {31'h0, ifid_en}, {31'h0, !s});
            chk("rnd_pc4", pc4, m_pc + 4);
            m_edge(s, w, r, t);
            edge_wait();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_pend", {31'h0, redir_pend}, {31'h0, (m_pendq.size() != 0)});
            chk("rnd_cnt", fetch_cnt, m_cnt);
            chk("rnd_adel", {31'h0, pc_adel}, {31'h0, m_adel});
            if (n % 50 == 0)
                $display("rnd %0d: s=%0b w=%0b r=%0b t=%h pc=%h cnt=%0d", n, s, w, r, t, pc, fetch_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
